adder_feeder: RTL
=================

// Module: adder_feeder
// PURPOSE
//  Issue-side partner of the adder: pops operand pairs from an input FIFO and drives them into the adder.
//  Drives addend1/addend2/dataAvailible, waits for complete, then writes sum to an output FIFO.
//  Acknowledges each result with out_rd_en. Runs a start-triggered batch of N pairs.
// PARAMETERS
//  DATA_WIDTH   32     operand/sum width; must match the adder
//  CNT_WIDTH    16     width of pair counter / batch length
//  TIMEOUT      64     max cycles waiting for complete before error
// PORTS
//  clock         in   1           single clock, rising edge
//  reset         in   1           asynchronous, active-low
//  start         in   1           1-cycle pulse; latch pair_count, begin batch (ignored while busy)
//  pair_count    in   CNT_WIDTH   pairs in batch; 0 => immediate done
//  in_dout       in   DATA_WIDTH  input FIFO head word (first-word-fall-through)
//  in_empty      in   1           input FIFO empty
//  in_rd_en      out  1           pop input FIFO
//  addend1       out  DATA_WIDTH  to adder, registered
//  addend2       out  DATA_WIDTH  to adder, registered
//  dataAvailible out  1           to adder, 1-cycle issue strobe
//  sum           in   DATA_WIDTH  from adder
//  complete      in   1           from adder, result held valid
//  out_rd_en     out  1           to adder, result acknowledge
//  out_din       out  DATA_WIDTH  output FIFO write data (= sum, combinational)
//  out_full      in   1           output FIFO full
//  out_wr_en     out  1           output FIFO push
//  busy          out  1           batch in progress
//  done          out  1           1-cycle pulse at batch end
//  error         out  1           sticky timeout flag; cleared by next accepted start
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE.
//   All outputs 0: addends, strobes, busy, done, error. Counters 0.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> ISSUE -> WAIT -> WRITE -> (LOAD_A | FINISH); FINISH -> IDLE.
//  IDLE: on start: remaining<=pair_count, error<=0, busy<=1.
//   pair_count==0 -> FINISH; else -> LOAD_A.
//  LOAD_A: if !in_empty: in_rd_en=1, addend1<=in_dout, -> LOAD_B. Else stall (no timeout).
//  LOAD_B: same, capturing addend2 -> ISSUE.
//  ISSUE: dataAvailible=1 for exactly one cycle; addends held; tmo<=0 -> WAIT.
//  WAIT: addends held stable (the adder samples them until complete).
//   complete==1 -> WRITE.
//   Else tmo++; tmo==TIMEOUT-1 -> error<=1, -> FINISH (batch aborted).
//  WRITE: when !out_full: out_wr_en=1 and out_rd_en=1 in the same cycle; remaining--.
//   remaining==1 -> FINISH, else LOAD_A.
//   If out_full: hold both low, stay (no timeout; backpressure legal).
//  FINISH: done=1 one cycle, busy<=0 -> IDLE.
//  Throughput: 5 cycles/pair minimum (LOAD_A, LOAD_B, ISSUE, WAIT>=1, WRITE).
//  in_rd_en only when !in_empty; out_wr_en only when !out_full; never both strobes in one cycle.
//  start while busy: ignored, no effect on count. Widths: no arithmetic on data; sum passed unmodified.
//  Reset mid-batch: immediate return to IDLE; partial results already written remain; no done pulse.
// STRUCTURE
//  Package adder_pkg: typedef enum logic [2:0] feeder_state_t {IDLE,LOAD_A,LOAD_B,ISSUE,WAIT,WRITE,FINISH}.
//   Also DATA_WIDTH default constant, shared with the adder.
//  Single module; FSM + remaining counter + timeout counter. No sub-module.
// TESTING (bench instantiates adder + two FIFOs)
//  pair_count=1, in FIFO {3,4} -> out FIFO {7}; done pulse; busy low after; error=0.
//  pair_count=3, in {1,2,0xFFFFFFFF,1,10,20} -> out {3,0,30} (wrap modulo 2^32).
//  in_empty asserted 20 cycles between words -> same results, no error, no extra in_rd_en.
//  out_full held 10 cycles in WRITE -> out_wr_en/out_rd_en low throughout; result written once on release.
//  complete stubbed low -> error=1 after TIMEOUT cycles in WAIT; done pulses; next start clears error.
//  reset low during WAIT of pair 2 of 3 -> all outputs 0 immediately; out FIFO holds only pair 1.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the adder and its issue-side feeder.
//   - ADDER_DATA_WIDTH : default operand/sum width used by both blocks
//   - feeder_state_t   : state encoding of the adder_feeder control FSM
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        WRITE  = 3'd5,
        FINISH = 3'd6
    } feeder_state_t;

endpackage : adder_pkg

// File: rtl/adder_feeder.sv
// -----------------------------------------------------------------------------
// adder_feeder
//   Issue-side partner of the adder. On a start pulse it runs a batch of
//   pair_count operand pairs: each pair is popped from a first-word-fall-through
//   input FIFO, presented to the adder with a one-cycle dataAvailible strobe,
//   and once the adder reports complete the sum is pushed to the output FIFO
//   while the result is acknowledged back to the adder in the same cycle.
//   A batch aborts with a sticky error if the adder does not complete within
//   TIMEOUT cycles.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   start         in   1-cycle pulse, latches pair_count (ignored while busy)
//   pair_count    in   number of pairs in the batch (0 => immediate done)
//   in_dout       in   input FIFO head word
//   in_empty      in   input FIFO empty
//   in_rd_en      out  input FIFO pop
//   addend1/2     out  registered operands to the adder
//   dataAvailible out  one-cycle issue strobe to the adder
//   sum           in   adder result
//   complete      in   adder result valid (held until acknowledged)
//   out_rd_en     out  adder result acknowledge
//   out_din       out  output FIFO write data (sum passed straight through)
//   out_full      in   output FIFO full
//   out_wr_en     out  output FIFO push
//   busy          out  batch in progress
//   done          out  one-cycle pulse at batch end
//   error         out  sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module adder_feeder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = ADDER_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  pair_count,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] addend1,
    output logic [DATA_WIDTH-1:0] addend2,
    output logic                  dataAvailible,
    input  logic [DATA_WIDTH-1:0] sum,
    input  logic                  complete,
    output logic                  out_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

    feeder_state_t           state_r;
    feeder_state_t           state_s;
    logic [CNT_WIDTH-1:0]    remaining_r;
    logic [TMO_W-1:0]        tmo_r;
    logic [DATA_WIDTH-1:0]   addend1_r;
    logic [DATA_WIDTH-1:0]   addend2_r;
    logic                    busy_r;
    logic                    error_r;
    logic                    in_rd_en_s;
    logic                    out_wr_en_s;
    logic                    data_avail_s;
    logic                    done_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (pair_count == '0) begin
                        state_s = FINISH;
                    end else begin
                        state_s = LOAD_A;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_A: begin
                if (!in_empty) begin
                    state_s = LOAD_B;
                end else begin
                    state_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (!in_empty) begin
                    state_s = ISSUE;
                end else begin
                    state_s = LOAD_B;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (complete) begin
                    state_s = WRITE;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = FINISH;
                end else begin
                    state_s = WAIT;
                end
            end
            WRITE: begin
                if (out_full) begin
                    state_s = WRITE;
                end else if (remaining_r == CNT_ONE) begin
                    state_s = FINISH;
                end else begin
                    state_s = LOAD_A;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Strobe decode; pop/push are gated by FIFO status so they never fire illegally.
    always_comb begin
        in_rd_en_s   = 1'b0;
        out_wr_en_s  = 1'b0;
        data_avail_s = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            LOAD_A, LOAD_B: in_rd_en_s   = ~in_empty;
            ISSUE:          data_avail_s = 1'b1;
            WRITE:          out_wr_en_s  = ~out_full;
            FINISH:         done_s       = 1'b1;
            default: begin
                in_rd_en_s   = 1'b0;
                out_wr_en_s  = 1'b0;
                data_avail_s = 1'b0;
                done_s       = 1'b0;
            end
        endcase
    end

    // Operand capture, batch counter, timeout counter and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_r <= '0;
            tmo_r       <= '0;
            addend1_r   <= '0;
            addend2_r   <= '0;
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        remaining_r <= pair_count;
                        error_r     <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (!in_empty) begin
                        addend1_r <= in_dout;
                    end
                end
                LOAD_B: begin
                    if (!in_empty) begin
                        addend2_r <= in_dout;
                    end
                end
                ISSUE: begin
                    tmo_r <= '0;
                end
                WAIT: begin
                    // Addends stay untouched here: the adder samples them until complete.
                    if (!complete) begin
                        tmo_r <= tmo_r + TMO_ONE;
                        if (tmo_r == TMO_LAST) begin
                            error_r <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!out_full) begin
                        remaining_r <= remaining_r - CNT_ONE;
                    end
                end
                FINISH: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

    assign addend1       = addend1_r;
    assign addend2       = addend2_r;
    assign dataAvailible = data_avail_s;
    assign in_rd_en      = in_rd_en_s;
    assign out_wr_en     = out_wr_en_s;
    assign out_rd_en     = out_wr_en_s;   // result is acknowledged exactly when it is stored
    assign out_din       = sum;
    assign busy          = busy_r;
    assign done          = done_s;
    assign error         = error_r;

endmodule : adder_feeder
